// File: rtl/sudoku_pkg.sv
// Shared constants for the game controller button front end.
// Holds the default debounce and auto-repeat timing, and the channel index
// assignment that every btn_level / pulse vector follows.
package sudoku_pkg;

  localparam int DB_CYCLES_DEF     = 4;
  localparam int REPEAT_DELAY_DEF  = 16;
  localparam int REPEAT_PERIOD_DEF = 8;

  localparam int NUM_BTN     = 3;
  localparam int BTN_ENTER   = 0;
  localparam int BTN_INSERT  = 1;
  localparam int BTN_RESTART = 2;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button/command bundle between the raw push-buttons and the main game FSM.
// The conditioner is the slave: it takes the raw buttons and drives the
// cleaned one-cycle commands and the debounced levels.
interface btn_conditioner_if;
  import sudoku_pkg::*;

  logic     btn_enter;
  logic     btn_insert;
  logic     btn_restart;
  logic     enter;
  logic     insert;
  logic     restart;
  btn_vec_t btn_level;

  modport master (
    output btn_enter, btn_insert, btn_restart,
    input  enter, insert, restart, btn_level
  );

  modport slave (
    input  btn_enter, btn_insert, btn_restart,
    output enter, insert, restart, btn_level
  );

endinterface

// File: rtl/btn_conditioner_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter and rising-edge
// pulse. The pulse register is loaded on the same edge that flips the
// debounced level to 1, so it is high for exactly one cycle per press.
module btn_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = $clog2(DB_CYCLES) + 1
) (
  input  logic clka,
  input  logic restart_n,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clka domain.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Flip the debounced level only after a full run of disagreeing samples; any
  // agreeing sample restarts the run, and only a 0->1 flip raises the pulse.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else if (s2 == level) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= s2;
      pulse <= s2;
    end else begin
      cnt   <= cnt + 1'b1;
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Game controller button front end: one debounce channel per button, then a
// priority mux (restart > enter > insert) on the registered pulses.
// Optional feature macro: BTN_AUTOREPEAT_EN adds insert auto-repeat while the
// insert button stays held. Without it, insert behaves exactly like enter.
module btn_conditioner
  import sudoku_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEF
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic             clka,
  input  logic             restart_n,
  btn_conditioner_if.slave bus
);

  btn_vec_t raw;
  btn_vec_t level;
  btn_vec_t pulse;
  logic     insert_src;
  logic     enter_out;
  logic     insert_out;
  logic     restart_out;

  assign raw[BTN_ENTER]   = bus.btn_enter;
  assign raw[BTN_INSERT]  = bus.btn_insert;
  assign raw[BTN_RESTART] = bus.btn_restart;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
      .clka      (clka),
      .restart_n (restart_n),
      .btn       (raw[i]),
      .level     (level[i]),
      .pulse     (pulse[i])
    );
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY) + 1;
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_pulse;

  // Count held-insert cycles; after the first repeat the counter reloads so
  // later repeats come every REPEAT_PERIOD cycles. Enter/restart output or
  // insert release restarts the whole sequence.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      rep_cnt   <= '0;
      rep_pulse <= 1'b0;
    end else if (!level[BTN_INSERT] || enter_out || restart_out) begin
      rep_cnt   <= '0;
      rep_pulse <= 1'b0;
    end else if (rep_cnt == REP_LAST) begin
      rep_cnt   <= REP_RELOAD;
      rep_pulse <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + 1'b1;
      rep_pulse <= 1'b0;
    end
  end

  assign insert_src = pulse[BTN_INSERT] | rep_pulse;
`else
  assign insert_src = pulse[BTN_INSERT];
`endif

  // Outputs come straight from registers through the priority gates, so they
  // only change right after a clka rising edge; suppressed pulses are lost.
  assign restart_out = pulse[BTN_RESTART];
  assign enter_out   = pulse[BTN_ENTER] & ~pulse[BTN_RESTART];
  assign insert_out  = insert_src & ~pulse[BTN_ENTER] & ~pulse[BTN_RESTART];

  assign bus.restart   = restart_out;
  assign bus.enter     = enter_out;
  assign bus.insert    = insert_out;
  assign bus.btn_level = level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (default DB_CYCLES). Each cycle the
// bench drives the buttons, pushes the expected outputs for the coming edge
// into a scoreboard queue, and compares them just after that edge.
// Honours BTN_AUTOREPEAT_EN for the expected insert repeats.
module tb_btn_conditioner;
  import sudoku_pkg::*;

  localparam int DB  = DB_CYCLES_DEF;
  localparam int LAT = DB + 2;

  typedef struct {
    logic [2:0] btns;
    int         hold;
    string      name;
  } vec_t;

  typedef struct {
    logic [2:0] pulse;
    logic [2:0] level;
    string      name;
    int         edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  btn_conditioner_if bus ();

  btn_conditioner dut (
    .clka      (clk),
    .restart_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] prio(input logic [2:0] b);
    if (b[2])      return 3'b100;
    else if (b[0]) return 3'b001;
    else if (b[1]) return 3'b010;
    else           return 3'b000;
  endfunction

  // Expected {restart,insert,enter} right after edge k when b is raised
  // before edge 1 and held for h edges.
  function automatic logic [2:0] exp_pulse_at(input logic [2:0] b, input int h, input int k);
    logic [2:0] p;
    p = 3'b000;
    if (h >= DB && k == LAT) p = prio(b);
`ifdef BTN_AUTOREPEAT_EN
    if (h >= DB && prio(b) == 3'b010 && k >= LAT + REPEAT_DELAY_DEF &&
        k < h + LAT && ((k - LAT - REPEAT_DELAY_DEF) % REPEAT_PERIOD_DEF) == 0)
      p = 3'b010;
`endif
    return p;
  endfunction

  function automatic logic [2:0] exp_level_at(input logic [2:0] b, input int h, input int k);
    if (h >= DB && k >= LAT && k < h + LAT) return b;
    return 3'b000;
  endfunction

  task automatic check_output();
    exp_t       e;
    logic [2:0] act_p;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: no expectation queued for DUT output");
      return;
    end
    e     = sb_q.pop_front();
    act_p = {bus.restart, bus.insert, bus.enter};
    tests_run++;
    if (act_p !== e.pulse || bus.btn_level !== e.level) begin
      tests_failed++;
      $display("[TB] FAIL %s edge %0d: got pulses=%b level=%b, expected pulses=%b level=%b",
               e.name, e.edge_no, act_p, bus.btn_level, e.pulse, e.level);
    end
  endtask

  // Drive one cycle of buttons, queue its expectation, compare after the edge.
  task automatic apply_stimulus(input logic [2:0] btns, input logic [2:0] ep,
                                input logic [2:0] el, input string name, input int k);
    exp_t e;
    @(negedge clk);
    bus.btn_enter   = btns[0];
    bus.btn_insert  = btns[1];
    bus.btn_restart = btns[2];
    e.pulse = ep; e.level = el; e.name = name; e.edge_no = k;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic run_vector(input logic [2:0] b, input int h, input string name);
    for (int k = 1; k <= h + LAT + 4; k++)
      apply_stimulus((k <= h) ? b : 3'b000, exp_pulse_at(b, h, k), exp_level_at(b, h, k), name, k);
  endtask

  task automatic check_now(input string name);
    exp_t e;
    e.pulse = 3'b000; e.level = 3'b000; e.name = name; e.edge_no = 0;
    sb_q.push_back(e);
    #1;
    check_output();
  endtask

  vec_t vecs[$];
  logic [8:0] bounce;

  initial begin
    rst_n           = 1'b0;
    bus.btn_enter   = 1'b0;
    bus.btn_insert  = 1'b0;
    bus.btn_restart = 1'b0;

    vecs.push_back('{3'b001, 8,   "enter_press"});
    vecs.push_back('{3'b010, 3,   "insert_glitch"});
    vecs.push_back('{3'b101, 8,   "enter_restart_same"});
    vecs.push_back('{3'b010, 100, "insert_held"});
    vecs.push_back('{3'b011, 8,   "enter_insert_same"});
    vecs.push_back('{3'b100, DB,  "restart_min_hold"});
    vecs.push_back('{3'b100, DB-1,"restart_short"});
    vecs.push_back('{3'b111, 6,   "all_three"});
    vecs.push_back('{3'b010, 10,  "insert_press"});

    repeat (3) @(posedge clk);
    check_now("reset_state");
    #1 rst_n = 1'b1;

    foreach (vecs[i]) run_vector(vecs[i].btns, vecs[i].hold, vecs[i].name);

    // Bouncy enter: only the first run of DB high samples counts.
    bounce = 9'b1_1110_1101;
    for (int k = 1; k <= 30; k++)
      apply_stimulus({2'b00, (k <= 9) ? bounce[k-1] : (k <= 20)},
                     (k == 11) ? 3'b001 : 3'b000,
                     (k >= 11 && k < 26) ? 3'b001 : 3'b000, "bouncy_enter", k);

    // Reset while a pulse is on the outputs clears them immediately.
    for (int k = 1; k <= LAT; k++)
      apply_stimulus(3'b001, exp_pulse_at(3'b001, 50, k), exp_level_at(3'b001, 50, k), "pre_reset_press", k);
    rst_n = 1'b0;
    check_now("async_reset_clear");
    for (int k = 1; k <= 3; k++) apply_stimulus(3'b000, 3'b000, 3'b000, "in_reset_idle", k);
    #1 rst_n = 1'b1;

    // Reset mid-count with enter held: the press restarts from scratch.
    for (int k = 1; k <= 4; k++) apply_stimulus(3'b001, 3'b000, 3'b000, "pre_reset_count", k);
    rst_n = 1'b0;
    check_now("reset_mid_count");
    for (int k = 1; k <= 3; k++) apply_stimulus(3'b001, 3'b000, 3'b000, "in_reset_held", k);
    #1 rst_n = 1'b1;
    run_vector(3'b001, 12, "reset_release_held");

    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
